mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Iterative multiply/divide engine for MULT, MULTU, DIV and DIVU. Drives the High/Low
//  register pair through their D/en write ports.
//  Sits beside the ALU in the MIPS32 datapath. The control unit issues a start pulse,
//  and the unit raises busy until the result is written.
//  One bit per cycle: radix-2 shift-add multiply and restoring divide.
// PARAMETERS
//  WIDTH  32  operand width; hi_data and lo_data are each WIDTH bits
// PORTS
//  clk      in   1      clock; all state updates on the rising edge
//  rst      in   1      asynchronous, active-high reset
//  start    in   1      request; sampled only in IDLE
//  op       in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
//  a        in   WIDTH  rs: multiplicand or dividend; sampled with start
//  b        in   WIDTH  rt: multiplier or divisor; sampled with start
//  busy     out  1      high in every state except IDLE
//  done     out  1      one-cycle pulse when the result is written
//  hi_data  out  WIDTH  to High.D: product[2W-1:W] or remainder
//  lo_data  out  WIDTH  to Low.D: product[W-1:0] or quotient
//  hi_en    out  1      to High.en; equal to done
//  lo_en    out  1      to Low.en; equal to done
// BEHAVIOUR
//  States: IDLE -> CALC -> FIX -> DONE -> IDLE.
//  Reset:
//   - State goes to IDLE; busy, done, hi_en, lo_en = 0; hi_data and lo_data = 0.
//   - Reset during any state aborts the operation with no en pulse.
//  Edge 0 (IDLE, start=1):
//   - Latch op and the signs of a and b.
//   - Load magnitudes: |a| and |b| for signed ops, raw a and b for unsigned ops.
//   - Clear the 2W-bit accumulator and the iteration count; go to CALC.
//  Edges 1..W (CALC), one bit per edge:
//   - Multiply: if the multiplier LSB is 1, add the multiplicand to the upper half;
//     then shift right by 1.
//   - Divide: shift the remainder:quotient pair left by 1; trial-subtract the divisor;
//     if the result is non-negative, keep it and set the quotient bit.
//   - Go to FIX when count == W-1. All arithmetic is unsigned on W+1 bits to hold the carry.
//  Edge W+1 (FIX):
//   - MULT: negate the 2W-bit product if sign(a) != sign(b).
//   - DIV: negate the quotient if the signs differ; negate the remainder if a < 0.
//   - Divide by zero (b == 0, DIV or DIVU): lo = all ones, hi = a unmodified, no sign fix.
//   - Overflow 0x80000000 / -1 (DIV) yields lo = 0x80000000, hi = 0 with no special case.
//   - Register hi_data and lo_data; go to DONE.
//  DONE cycle (after edge W+1):
//   - done = hi_en = lo_en = 1. The High/Low registers capture at edge W+2, and the state returns to IDLE.
//   - Latency: done is asserted W+1 edges after the edge that sampled start (33 for W=32).
//  Other rules:
//   - start while busy is ignored and not queued.
//   - start in the DONE cycle is ignored. A new operation can be accepted from the IDLE cycle after DONE.
//   - hi_data and lo_data hold the last result until the next FIX. a, b and op may change after edge 0.
// TESTING
//  1. MULTU a=FFFFFFFF, b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001; done exactly 33 edges after start.
//  2. MULT a=FFFFFFFD (-3), b=5 -> hi=FFFFFFFF, lo=FFFFFFF1 (-15); hi_en=lo_en=1 for exactly one cycle.
//  3. DIV a=FFFFFFF9 (-7), b=2 -> lo=FFFFFFFD (-3), hi=FFFFFFFF (-1).
//     DIVU a=100, b=7 -> lo=0000000E, hi=00000002.
//  4. DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0.
//     DIVU a=12345678, b=0 -> lo=FFFFFFFF, hi=12345678.
//  5. start held high during busy with changing a and b -> no second operation and the first result is intact.
//     Back-to-back starts: the second is accepted in the IDLE cycle after DONE.
//  6. rst pulsed mid-CALC (edge 10) -> busy=0 immediately; no done/en pulse; hi_data=lo_data=0.
//     The next start completes normally.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// Multiply/divide request and result bundle.
// master: control unit side; slave: the engine.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi_data;
    logic [WIDTH-1:0] lo_data;
    logic             hi_en;
    logic             lo_en;

    modport master (
        output start, op, a, b,
        input  busy, done, hi_data, lo_data, hi_en, lo_en
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi_data, lo_data, hi_en, lo_en
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply / restoring divide for MULT, MULTU, DIV, DIVU.
// Results go to the High/Low register pair via hi/lo data and enables.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input logic            clk,
    input logic            rst,
    mult_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [1:0]         r_op;
    logic               r_sa;
    logic               r_sb;
    logic               r_bz;
    logic [WIDTH-1:0]   r_ma;
    logic [WIDTH-1:0]   r_mb;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_sgn;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_madd;
    logic [2*WIDTH-1:0] w_mul_nxt;
    logic [WIDTH:0]     w_rsh;
    logic [WIDTH+1:0]   w_diff;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_div_nxt;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    always_comb begin
        w_sgn   = ~bus.op[0];
        w_abs_a = (w_sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        w_abs_b = (w_sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;

        // Multiply: r_mb is the shifting multiplier, r_ma the multiplicand.
        w_madd    = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                  + (r_mb[0] ? {1'b0, r_ma} : '0);
        w_mul_nxt = {w_madd, r_acc[WIDTH-1:1]};

        // Divide: dividend bits stream in from the MSB of r_mb.
        w_rsh     = {r_acc[2*WIDTH-1:WIDTH], r_mb[WIDTH-1]};
        w_diff    = {1'b0, w_rsh} - {2'b00, r_ma};
        w_ge      = ~w_diff[WIDTH+1];
        w_div_nxt = {w_ge ? w_diff[WIDTH-1:0] : w_rsh[WIDTH-1:0],
                     r_acc[WIDTH-2:0], w_ge};

        w_prod = (r_sa ^ r_sb) ? -r_acc : r_acc;
        w_quo  = r_acc[WIDTH-1:0];
        w_rem  = r_acc[2*WIDTH-1:WIDTH];

        // A zero divisor leaves |a| as remainder; re-signing restores raw a.
        if (r_op[1]) begin
            w_fix_hi = r_sa ? -w_rem : w_rem;
            w_fix_lo = r_bz ? '1 : ((r_sa ^ r_sb) ? -w_quo : w_quo);
        end else begin
            w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
            w_fix_lo = w_prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_bz    <= 1'b0;
            r_ma    <= '0;
            r_mb    <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op    <= bus.op;
                        r_sa    <= w_sgn & bus.a[WIDTH-1];
                        r_sb    <= w_sgn & bus.b[WIDTH-1];
                        r_bz    <= (bus.b == '0);
                        r_ma    <= bus.op[1] ? w_abs_b : w_abs_a;
                        r_mb    <= bus.op[1] ? w_abs_a : w_abs_b;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_acc <= r_op[1] ? w_div_nxt : w_mul_nxt;
                    r_mb  <= r_op[1] ? (r_mb << 1) : (r_mb >> 1);
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH - 1))
                        r_state <= S_FIX;
                end
                S_FIX: begin
                    r_hi    <= w_fix_hi;
                    r_lo    <= w_fix_lo;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.hi_en   = r_done;
    assign bus.lo_en   = r_done;
    assign bus.hi_data = r_hi;
    assign bus.lo_data = r_lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected High/Low pushed at issue,
// popped and compared on each done pulse.
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errs = 0;
    int   checks = 0;
    logic prev_done = 1'b0;
    logic [63:0] q[$];

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, qq, rm;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0: r = sa * sb;
            2'd1: r = {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else begin
                    qq = sa / sb;
                    rm = sa % sb;
                    r = {rm[31:0], qq[31:0]};
                end
            end
            default: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        logic [63:0] e;
        if (rst) begin
            prev_done = 1'b0;
        end else begin
            if (prev_done)
                chk("en_off", {61'd0, bus.done, bus.hi_en, bus.lo_en}, 64'd0);
            if (bus.done) begin
                chk("en_on", {62'd0, bus.hi_en, bus.lo_en}, 64'd3);
                if (q.size() == 0) begin
                    chk("extra_done", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("hi", {32'd0, bus.hi_data}, {32'd0, e[63:32]});
                    chk("lo", {32'd0, bus.lo_data}, {32'd0, e[31:0]});
                end
            end
            prev_done = bus.done;
        end
    end

    task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        int n;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        q.push_back(model(op, a, b));
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op = 2'($urandom_range(0, 3));
        bus.a = $urandom;
        bus.b = $urandom;
        chk("busy_on", {63'd0, bus.busy}, 64'd1);
        n = 0;
        while (!bus.done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", 64'(n), 64'd33);
        @(posedge clk);
        #1;
        chk("busy_off", {63'd0, bus.busy}, 64'd0);
    endtask

    initial begin
        int n;
        bus.start = 1'b0;
        bus.op = 2'd0;
        bus.a = '0;
        bus.b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_en", {61'd0, bus.done, bus.hi_en, bus.lo_en}, 64'd0);
        chk("rst_hilo", {bus.hi_data, bus.lo_data}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(2'd0, 32'hFFFF_FFFD, 32'd5);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2);
        run_op(2'd3, 32'd100, 32'd7);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(2'd3, 32'h1234_5678, 32'd0);
        run_op(2'd2, 32'hFFFF_FF00, 32'd0);
        run_op(2'd0, 32'h8000_0000, 32'h8000_0000);
        for (int i = 0; i < 8; i++)
            run_op(2'($urandom_range(0, 3)), $urandom,
                   ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom);

        // start held high through busy, then back-to-back acceptance
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = 2'd1;
        bus.a = 32'h0001_0003;
        bus.b = 32'h0000_0007;
        q.push_back(model(2'd1, 32'h0001_0003, 32'h0000_0007));
        n = 0;
        while (!bus.done && n < 40) begin
            @(negedge clk);
            bus.a = $urandom;
            bus.b = $urandom;
            bus.op = 2'($urandom_range(0, 3));
            n++;
        end
        chk("hold_bound", 64'(n < 40), 64'd1);
        bus.op = 2'd3;
        bus.a = 32'd1000;
        bus.b = 32'd10;
        q.push_back(model(2'd3, 32'd1000, 32'd10));
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("b2b_busy", {63'd0, bus.busy}, 64'd1);
        n = 0;
        while (!bus.done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("b2b_latency", 64'(n), 64'd33);
        repeat (3) @(negedge clk);
        chk("hold_result", {bus.hi_data, bus.lo_data}, {32'd0, 32'd100});

        // reset mid-CALC aborts without an enable pulse
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = 2'd0;
        bus.a = 32'd1234;
        bus.b = 32'd5678;
        q.push_back(model(2'd0, 32'd1234, 32'd5678));
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        q.delete();
        chk("abort_busy", {63'd0, bus.busy}, 64'd0);
        chk("abort_en", {61'd0, bus.done, bus.hi_en, bus.lo_en}, 64'd0);
        chk("abort_hilo", {bus.hi_data, bus.lo_data}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        run_op(2'd2, 32'd77, 32'hFFFF_FFF8);

        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
